// File: rtl/led_animator.sv
// rtl/led_animator.sv - LED pattern sequencer (BOUNCE/ROT_L/FILL/ROT_R) with step prescaler.
// Optional cycle_done pulse output is enabled by defining LED_ANIM_CYCLE_EN.
module led_animator #(
    parameter int WIDTH = 18,
    parameter int DIV_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] leds,
    output logic             step,
    output logic             dir
`ifdef LED_ANIM_CYCLE_EN
    ,
    output logic             cycle_done
`endif
);

    typedef enum logic [1:0] {
        M_BOUNCE = 2'd0,
        M_ROT_L  = 2'd1,
        M_FILL   = 2'd2,
        M_ROT_R  = 2'd3
    } mode_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);

    mode_e            mode_d, mode_q;
    logic [DIV_W-1:0] cnt_d, cnt_q;
    logic [WIDTH-1:0] leds_d, leds_q;
    logic             step_d, step_q;
    logic             dir_d, dir_q;
    logic             bdir;
    logic             mode_chg;
    logic             adv;

    assign mode_d   = mode_e'(mode);
    assign mode_chg = (mode_d != mode_q);
    assign adv      = !mode_chg && en && (cnt_q >= div);

    always_comb begin
        cnt_d  = cnt_q;
        leds_d = leds_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        bdir   = dir_q;
        if (mode_chg) begin
            // Reinit wins over en and any pending advance
            cnt_d  = '0;
            dir_d  = 1'b0;
            leds_d = (mode_d == M_FILL) ? '0 : ONE;
        end else if (en) begin
            if (adv) begin
                cnt_d  = '0;
                step_d = 1'b1;
                case (mode_q)
                    M_BOUNCE: begin
                        if (leds_q == '0) begin
                            leds_d = ONE;
                        end else begin
                            bdir   = leds_q[0] ? 1'b0 : (leds_q[WIDTH-1] ? 1'b1 : dir_q);
                            dir_d  = bdir;
                            leds_d = bdir ? (leds_q >> 1) : (leds_q << 1);
                        end
                    end
                    M_ROT_L: begin
                        leds_d = (leds_q == '0) ? ONE : {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
                    end
                    M_ROT_R: begin
                        leds_d = (leds_q == '0) ? ONE : {leds_q[0], leds_q[WIDTH-1:1]};
                    end
                    M_FILL: begin
                        if (!dir_q) begin
                            leds_d = {leds_q[WIDTH-2:0], 1'b1};
                            if (leds_d == '1) dir_d = 1'b1;
                        end else begin
                            leds_d = leds_q << 1;
                            if (leds_d == '0) dir_d = 1'b0;
                        end
                    end
                    default: leds_d = ONE;
                endcase
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= M_BOUNCE;
            cnt_q  <= '0;
            leds_q <= ONE;
            step_q <= 1'b0;
            dir_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            leds_q <= leds_d;
            step_q <= step_d;
            dir_q  <= dir_d;
        end
    end

    assign leds = leds_q;
    assign step = step_q;
    assign dir  = dir_q;

`ifdef LED_ANIM_CYCLE_EN
    logic cyc_d, cyc_q;

    // Flags the advance that lands back on each mode's starting pattern
    always_comb begin
        cyc_d = 1'b0;
        if (adv) begin
            case (mode_q)
                M_BOUNCE: cyc_d = dir_q && (leds_q == (ONE << 1));
                M_ROT_L:  cyc_d = (leds_q == MSB);
                M_FILL:   cyc_d = dir_q && ((leds_q << 1) == '0);
                M_ROT_R:  cyc_d = (leds_q == (ONE << 1));
                default:  cyc_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyc_q <= 1'b0;
        else     cyc_q <= cyc_d;
    end

    assign cycle_done = cyc_q;
`endif

endmodule

// File: tb/tb_led_animator.sv
// tb/tb_led_animator.sv - randomized and directed checks of led_animator against a position-based model.
module tb_led_animator;
    localparam int W  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic [DW-1:0] div;
    logic [W-1:0]  leds;
    logic          step;
    logic          dir;
`ifdef LED_ANIM_CYCLE_EN
    logic          cycle_done;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_animator #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .mode(mode),
        .div (div),
        .leds(leds),
        .step(step),
        .dir (dir)
`ifdef LED_ANIM_CYCLE_EN
        ,
        .cycle_done(cycle_done)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each mode is a cyclic walk over positions p; the pattern is a pure function of p.
    int m_cnt, m_p, m_mode;
    bit m_wrap, m_step, m_cd;

    function automatic int period(input int md);
        case (md)
            0:       return 2 * (W - 1);
            2:       return 2 * W;
            default: return W;
        endcase
    endfunction

    function automatic logic [W-1:0] pat(input int md, input int p);
        int v;
        case (md)
            0:       v = 1 << ((p < W) ? p : 2 * (W - 1) - p);
            1:       v = 1 << p;
            3:       v = 1 << ((W - p) % W);
            default: v = (p <= W) ? ((1 << p) - 1) : (((1 << W) - 1) << (p - W));
        endcase
        return v[W-1:0];
    endfunction

    function automatic bit pdir(input int md, input int p, input bit wrap);
        if (md == 0) return (p >= W) || (p == 0 && wrap);
        if (md == 2) return p >= W;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_p = 0; m_wrap = 0; m_mode = 0; m_step = 0; m_cd = 0;
        end else begin
            m_step = 0;
            m_cd   = 0;
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode); m_cnt = 0; m_p = 0; m_wrap = 0;
            end else if (en) begin
                if (m_cnt >= int'(div)) begin
                    m_cnt  = 0;
                    m_step = 1;
                    m_p    = (m_p + 1) % period(m_mode);
                    m_wrap = (m_p == 0);
                    m_cd   = (m_p == 0);
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_leds", 32'(leds), 32'(pat(m_mode, m_p)));
        chk("model_step", 32'(step), 32'(m_step));
        chk("model_dir",  32'(dir),  32'(pdir(m_mode, m_p, m_wrap)));
`ifdef LED_ANIM_CYCLE_EN
        chk("model_cycle_done", 32'(cycle_done), 32'(m_cd));
`endif
    end

    logic [W-1:0] bnc_seq [7];
    logic         bnc_dir [7];
    logic [W-1:0] fill_seq [8];
    logic         fill_dir [8];
    logic [W-1:0] rotr_seq [4];
    logic [W-1:0] held;

    initial begin
        bnc_seq  = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        bnc_dir  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        fill_seq = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        fill_dir = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rotr_seq = '{4'h8, 4'h4, 4'h2, 4'h1};

        rst = 1'b1; en = 1'b1; mode = 2'd0; div = '0;
        @(negedge clk);
        chk("reset_leds", 32'(leds), 32'h1);
        chk("reset_step", 32'(step), 32'h0);
        chk("reset_dir",  32'(dir),  32'h0);
        rst = 1'b0;

        // Bounce at div=0
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("bounce_leds", 32'(leds), 32'(bnc_seq[i]));
            chk("bounce_dir",  32'(dir),  32'(bnc_dir[i]));
            chk("bounce_step", 32'(step), 32'h1);
        end

        // Fill at div=2
        mode = 2'd2; div = 8'd2;
        @(negedge clk);
        chk("fill_init_leds", 32'(leds), 32'h0);
        chk("fill_init_step", 32'(step), 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("fill_gap_step", 32'(step), 32'h0);
            @(negedge clk);
            chk("fill_gap_step", 32'(step), 32'h0);
            @(negedge clk);
            chk("fill_leds", 32'(leds), 32'(fill_seq[i]));
            chk("fill_dir",  32'(dir),  32'(fill_dir[i]));
            chk("fill_step", 32'(step), 32'h1);
`ifdef LED_ANIM_CYCLE_EN
            chk("fill_cycle_done", 32'(cycle_done), (i == 7) ? 32'h1 : 32'h0);
`endif
        end

        // ROT_L then switch to ROT_R at leds=4
        mode = 2'd1; div = '0;
        @(negedge clk); chk("rotl_init", 32'(leds), 32'h1);
        @(negedge clk); chk("rotl_1", 32'(leds), 32'h2);
        @(negedge clk); chk("rotl_2", 32'(leds), 32'h4);
        mode = 2'd3;
        @(negedge clk);
        chk("rotr_init_leds", 32'(leds), 32'h1);
        chk("rotr_init_step", 32'(step), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rotr_leds", 32'(leds), 32'(rotr_seq[i]));
            chk("rotr_step", 32'(step), 32'h1);
`ifdef LED_ANIM_CYCLE_EN
            chk("rotr_cycle_done", 32'(cycle_done), (i == 3) ? 32'h1 : 32'h0);
`endif
        end

        // Pause mid-count at cnt=3 with div=5
        mode = 2'd0; div = 8'd5;
        @(negedge clk);
        repeat (3) @(negedge clk);
        en = 1'b0;
        held = leds;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("pause_leds", 32'(leds), 32'(held));
            chk("pause_step", 32'(step), 32'h0);
        end
        en = 1'b1;
        @(negedge clk); chk("resume_step1", 32'(step), 32'h0);
        @(negedge clk); chk("resume_step2", 32'(step), 32'h0);
        @(negedge clk);
        chk("resume_step3", 32'(step), 32'h1);
        chk("resume_leds",  32'(leds), 32'h2);

        // Async reset in the middle of FILL
        mode = 2'd2; div = '0;
        @(negedge clk); chk("fill2_init", 32'(leds), 32'h0);
        repeat (3) @(negedge clk);
        chk("fill2_leds7", 32'(leds), 32'h7);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_leds", 32'(leds), 32'h1);
        chk("async_rst_dir",  32'(dir),  32'h0);
        chk("async_rst_step", 32'(step), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_reinit", 32'(leds), 32'h0);
        chk("post_rst_step",   32'(step), 32'h0);

        // Shrinking div mid-count
        mode = 2'd0; div = 8'd100;
        @(negedge clk);
        repeat (50) @(negedge clk);
        chk("bigdiv_no_step", 32'(step), 32'h0);
        div = 8'd2;
        @(negedge clk);
        chk("shrink_step", 32'(step), 32'h1);
        chk("shrink_leds", 32'(leds), 32'h2);
        @(negedge clk); chk("shrink_gap1", 32'(step), 32'h0);
        @(negedge clk); chk("shrink_gap2", 32'(step), 32'h0);
        @(negedge clk);
        chk("shrink_next_step", 32'(step), 32'h1);
        chk("shrink_next_leds", 32'(leds), 32'h4);

        // Randomized phase; the negedge compare process checks every cycle
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  en = ~en;
            if ($urandom_range(0, 15) == 0) div = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 499) == 0) begin
                #($urandom_range(1, 4)) rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_animator.md
Name: led_animator

Overview:
- Parametrised LED pattern sequencer that generalises the board's single bounce animation.
- Adds configurable width, four run-time-selectable modes, a built-in programmable step prescaler, and an enable/pause input.
- Drives the LEDR/LEDG banks of the test top directly from CLOCK_50; no external DivFreq is needed.

Parameters:
WIDTH, 18, number of LED outputs; legal range 4..32
DIV_W, 26, width of step-period divider input

Ports:
clk  in  1  system clock (CLOCK_50)
rst  in  1  reset, asynchronous, active-high
en  in  1  1 = run; 0 = freeze prescaler and pattern
mode  in  2  0 BOUNCE, 1 ROT_L, 2 FILL, 3 ROT_R
div  in  DIV_W  step period = div+1 clk cycles
leds  out  WIDTH  current pattern (registered)
step  out  1  one-cycle pulse on each pattern advance (registered)
dir  out  1  BOUNCE direction, 0 = toward MSB; FILL phase, 0 = filling (registered)

Behaviour:
Clocking and reset:
- Single clock. Reset is asynchronous and active-high.
- Reset values: leds=1, step=0, dir=0, prescaler cnt=0, mode_q=0 (BOUNCE), FILL phase=0.

Prescaler:
- When en=1: if cnt>=div, then cnt<=0 and advance; else cnt<=cnt+1.
- div=0 advances every clock.
- The >= compare makes shrinking div mid-count step on the next clock.
- step=1 for exactly the cycle after an advance is taken, aligned with the new leds value.
- When en=0: cnt, leds, dir hold and step=0.

Mode change:
- mode is registered as mode_q each clock.
- If mode!=mode_q, the block reinitialises in that same cycle:
  - cnt<=0, dir<=0, step<=0.
  - leds<=0 for FILL; leds<=1 for all other modes.
  - No advance is taken in that cycle.
- Mode change takes precedence over en and over a pending advance.

Advance rules (all shifts are WIDTH bits, zero-fill unless stated):
- BOUNCE: first evaluate direction: if leds[0] then dir<=0, else if leds[WIDTH-1] then dir<=1. Then shift by the new dir (0: <<1, 1: >>1). Sequence for WIDTH=4: 1,2,4,8,4,2,1,2,...
- ROT_L: leds<={leds[WIDTH-2:0],leds[WIDTH-1]}.
- ROT_R: leds<={leds[0],leds[WIDTH-1:1]}.
- FILL, dir=0: leds<={leds[WIDTH-2:0],1'b1}; when the result is all ones, dir<=1.
- FILL, dir=1: leds<=leds<<1; when the result is 0, dir<=0.
- Illegal/zero patterns in BOUNCE/ROT modes: if leds==0 at an advance, load 1 (self-recovery). This case is only reachable via a glitch.

dir output:
- Meaningful only in BOUNCE and FILL.
- Held at 0 in ROT_L and ROT_R.

Optional Feature:
Macro LED_ANIM_CYCLE_EN.
- Defined: adds output port cycle_done (out, 1). It is a registered one-cycle pulse, coincident with step, on the advance that returns the pattern to its initial value:
  - BOUNCE: 2->1 while dir=1.
  - ROT_L: MSB->1.
  - ROT_R: 2->1.
  - FILL: drain reaches 0.
  - cycle_done resets to 0 and is never asserted on a mode-change reinit.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=4, mode=0, div=0, en=1, release rst -> leds 1,2,4,8,4,2,1,2 on consecutive clocks; dir rises with leds=4 after 8; step high every cycle.
2. WIDTH=4, mode=2, div=2 -> leds advance every 3rd clock: 0,1,3,7,F,E,C,8,0. Phase dir goes 1 at F and 0 at 0. With LED_ANIM_CYCLE_EN, cycle_done pulses once with leds=0.
3. WIDTH=4, mode=1 then mode=3 at leds=4 -> the next clock shows leds=1, step=0, cnt=0. Then ROT_R sequence is 8,4,2,1; cycle_done (if enabled) fires at 1.
4. div=5, en dropped for 10 clocks mid-count at cnt=3 -> leds/step frozen. After re-enable, the advance occurs exactly 3 clocks later (cnt 3->4->5->advance).
5. rst asserted asynchronously mid-FILL (leds=7) between clock edges -> leds=1, dir=0, step=0 immediately without a clock edge. mode_q=0, so if mode=2 is still applied, the first clock after release reinitialises to leds=0.
6. div changed from 100 to 2 while cnt=50 -> advance on the next clock (cnt>=div), then every 3 clocks.
